// File: rtl/gobou_pkg.sv
// Shared gobou definitions: Q8.8 datapath widths, memory/mac latencies and
// the mac_seq state encoding.
package gobou_pkg;

    localparam int unsigned DWIDTH  = 16;
    localparam int unsigned FL      = 8;
    localparam int unsigned IAWIDTH = 12;
    localparam int unsigned WAWIDTH = 16;
    localparam int unsigned CWIDTH  = 12;
    localparam int unsigned RD_LAT  = 1;
    localparam int unsigned MAC_LAT = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_OUT   = 3'd3,
        ST_CLEAR = 3'd4
    } mac_seq_state_t;

endpackage

// File: rtl/valid_pipe.sv
// Shift register of per-element tag bits with two taps. Tap A gives the whole
// tag word at stage TAP_A; tap B gives only the valid bit (bit 0) at TAP_B.
module valid_pipe #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned TAP_A = 1,
    parameter int unsigned TAP_B = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] tap_a_o,
    output logic             tap_b_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // stage_q[k] holds the tag issued k+1 cycles ago
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q[0] <= in_i;
            for (int k = 1; k < DEPTH; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    assign tap_a_o = stage_q[TAP_A-1];
    assign tap_b_o = stage_q[TAP_B-1][0];

endmodule

// File: rtl/mac_seq.sv
// Fully-connected layer sequencer for the gobou mac: fetch, drain, out, clear
// per neuron. Define MAC_SEQ_BIAS_EN to append a bias element to every neuron.
module mac_seq #(
    parameter int unsigned DWIDTH  = gobou_pkg::DWIDTH,
    parameter int unsigned IAWIDTH = gobou_pkg::IAWIDTH,
    parameter int unsigned WAWIDTH = gobou_pkg::WAWIDTH,
    parameter int unsigned CWIDTH  = gobou_pkg::CWIDTH,
    parameter int unsigned RD_LAT  = gobou_pkg::RD_LAT,
    parameter int unsigned MAC_LAT = gobou_pkg::MAC_LAT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [CWIDTH-1:0]  n_in,
    input  logic [CWIDTH-1:0]  n_out,
    output logic               busy,
    output logic               done,
    output logic [IAWIDTH-1:0] x_addr,
    output logic [WAWIDTH-1:0] w_addr,
    input  logic [DWIDTH-1:0]  x_rdata,
    input  logic [DWIDTH-1:0]  w_rdata,
    output logic [DWIDTH-1:0]  mac_x,
    output logic [DWIDTH-1:0]  mac_w,
    output logic               accum_we,
    output logic               out_en,
    output logic               mac_reset,
    output logic               y_we,
    output logic [CWIDTH-1:0]  y_addr
`ifdef MAC_SEQ_BIAS_EN
    ,
    input  logic [DWIDTH-1:0]  b_rdata,
    output logic [CWIDTH-1:0]  b_addr
`endif
);

    import gobou_pkg::*;

    localparam int unsigned PIPE_LAT = RD_LAT + MAC_LAT;
    localparam int unsigned DR_W     = $clog2(PIPE_LAT + 1);
`ifdef MAC_SEQ_BIAS_EN
    localparam int unsigned PW = 2;
    localparam logic [DWIDTH-1:0] ONE_Q = DWIDTH'(1) << FL;
`else
    localparam int unsigned PW = 1;
`endif

    mac_seq_state_t state_q, state_d;

    logic [CWIDTH-1:0]  n_in_q, n_in_d;
    logic [CWIDTH-1:0]  n_out_q, n_out_d;
    logic [CWIDTH-1:0]  i_q, i_d;
    logic [CWIDTH-1:0]  o_q, o_d;
    logic [WAWIDTH-1:0] w_q, w_d;
    logic [DR_W-1:0]    dr_q, dr_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               out_en_q, out_en_d;
    logic               clr_q, clr_d;
    logic [CWIDTH-1:0]  y_addr_q, y_addr_d;

    logic               issue;
    logic               last_elem;
    logic               bias_elem;
    logic               has_elem_new;
    logic               has_elem;
    logic               last_neuron;
    logic [PW-1:0]      pipe_in;
    logic [PW-1:0]      tap_a;
    logic               tap_b;

    // With a bias the element list is n_in data items plus one bias item.
`ifdef MAC_SEQ_BIAS_EN
    assign has_elem_new = 1'b1;
    assign has_elem     = 1'b1;
    assign last_elem    = (i_q == n_in_q);
    assign bias_elem    = (i_q == n_in_q);
`else
    assign has_elem_new = (n_in != '0);
    assign has_elem     = (n_in_q != '0);
    assign last_elem    = (i_q == n_in_q - CWIDTH'(1));
    assign bias_elem    = 1'b0;
`endif

    assign issue       = (state_q == ST_FETCH);
    assign last_neuron = (o_q == n_out_q - CWIDTH'(1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start && (n_out != '0)) begin
                    state_d = has_elem_new ? ST_FETCH : ST_OUT;
                end
            end
            ST_FETCH: begin
                if (last_elem) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (dr_q == DR_W'(1)) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (last_neuron) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = has_elem ? ST_FETCH : ST_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Counters: element index, neuron index, running weight address, drain
    always_comb begin
        n_in_d  = n_in_q;
        n_out_d = n_out_q;
        i_d     = i_q;
        o_d     = o_q;
        w_d     = w_q;
        dr_d    = dr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_in_d  = n_in;
                    n_out_d = n_out;
                    i_d     = '0;
                    o_d     = '0;
                    w_d     = '0;
                end
            end
            ST_FETCH: begin
                if (!bias_elem) begin
                    w_d = w_q + WAWIDTH'(1);
                end
                if (last_elem) begin
                    i_d  = '0;
                    dr_d = DR_W'(PIPE_LAT);
                end else begin
                    i_d = i_q + CWIDTH'(1);
                end
            end
            ST_DRAIN: begin
                dr_d = dr_q - DR_W'(1);
            end
            ST_CLEAR: begin
                if (!last_neuron) begin
                    o_d = o_q + CWIDTH'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Output decode, one cycle ahead of the registered outputs
    always_comb begin
        busy_d   = (state_d != ST_IDLE);
        done_d   = ((state_q == ST_IDLE) && start && (n_out == '0)) ||
                   ((state_q == ST_CLEAR) && last_neuron);
        out_en_d = (state_d == ST_OUT);
        clr_d    = (state_d == ST_CLEAR);
        y_addr_d = (state_d == ST_CLEAR) ? o_q : y_addr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n_in_q   <= '0;
            n_out_q  <= '0;
            i_q      <= '0;
            o_q      <= '0;
            w_q      <= '0;
            dr_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            out_en_q <= 1'b0;
            clr_q    <= 1'b0;
            y_addr_q <= '0;
        end else begin
            n_in_q   <= n_in_d;
            n_out_q  <= n_out_d;
            i_q      <= i_d;
            o_q      <= o_d;
            w_q      <= w_d;
            dr_q     <= dr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            out_en_q <= out_en_d;
            clr_q    <= clr_d;
            y_addr_q <= y_addr_d;
        end
    end

`ifdef MAC_SEQ_BIAS_EN
    assign pipe_in = {issue & bias_elem, issue};
`else
    assign pipe_in = issue;
`endif

    valid_pipe #(
        .WIDTH (PW),
        .DEPTH (PIPE_LAT),
        .TAP_A (RD_LAT),
        .TAP_B (PIPE_LAT)
    ) u_valid_pipe (
        .clk     (clk),
        .reset   (reset),
        .in_i    (pipe_in),
        .tap_a_o (tap_a),
        .tap_b_o (tap_b)
    );

    // Memory data arrives RD_LAT after issue; the tag at that stage gates it
`ifdef MAC_SEQ_BIAS_EN
    assign mac_x  = !tap_a[0] ? '0 : (tap_a[1] ? ONE_Q   : x_rdata);
    assign mac_w  = !tap_a[0] ? '0 : (tap_a[1] ? b_rdata : w_rdata);
    assign b_addr = o_q;
`else
    assign mac_x = tap_a[0] ? x_rdata : '0;
    assign mac_w = tap_a[0] ? w_rdata : '0;
`endif

    assign accum_we  = tap_b;
    assign x_addr    = IAWIDTH'(i_q);
    assign w_addr    = w_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_en    = out_en_q;
    assign mac_reset = clr_q;
    assign y_we      = clr_q;
    assign y_addr    = y_addr_q;

endmodule

// File: tb/tb_mac_seq.sv
// Randomised scoreboard bench for mac_seq: memories, a behavioural mac and a
// dot-product reference. Bias build is exercised when MAC_SEQ_BIAS_EN is set.
module tb_mac_seq;
    import gobou_pkg::*;

`ifdef MAC_SEQ_BIAS_EN
    localparam int BIAS = 1;
`else
    localparam int BIAS = 0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic [CWIDTH-1:0]  n_in = '0;
    logic [CWIDTH-1:0]  n_out = '0;
    logic               busy, done;
    logic [IAWIDTH-1:0] x_addr;
    logic [WAWIDTH-1:0] w_addr;
    logic [DWIDTH-1:0]  x_rdata = '0;
    logic [DWIDTH-1:0]  w_rdata = '0;
    logic [DWIDTH-1:0]  mac_x, mac_w;
    logic               accum_we, out_en, mac_reset, y_we;
    logic [CWIDTH-1:0]  y_addr;
`ifdef MAC_SEQ_BIAS_EN
    logic [DWIDTH-1:0]  b_rdata = '0;
    logic [CWIDTH-1:0]  b_addr;
    logic [DWIDTH-1:0]  b_mem [4096];
`endif

    logic [DWIDTH-1:0]  x_mem [4096];
    logic [DWIDTH-1:0]  w_mem [65536];

    always #5 clk = ~clk;

    mac_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .n_in      (n_in),
        .n_out     (n_out),
        .busy      (busy),
        .done      (done),
        .x_addr    (x_addr),
        .w_addr    (w_addr),
        .x_rdata   (x_rdata),
        .w_rdata   (w_rdata),
        .mac_x     (mac_x),
        .mac_w     (mac_w),
        .accum_we  (accum_we),
        .out_en    (out_en),
        .mac_reset (mac_reset),
        .y_we      (y_we),
        .y_addr    (y_addr)
`ifdef MAC_SEQ_BIAS_EN
        ,
        .b_rdata   (b_rdata),
        .b_addr    (b_addr)
`endif
    );

    // Synchronous memories with one cycle of read latency
    always @(posedge clk) begin
        x_rdata <= x_mem[x_addr];
        w_rdata <= w_mem[w_addr];
`ifdef MAC_SEQ_BIAS_EN
        b_rdata <= b_mem[b_addr];
`endif
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct {
        int     addr;
        longint acc;
    } exp_t;

    exp_t sb_q[$];

    longint acc = 0;
    longint ymod = 0;
    longint prod [MAC_LAT];
    int     done_cnt = 0;
    int     accw_cnt = 0;
    int     outen_cnt = 0;

    // Behavioural mac fed by the DUT, plus the scoreboard monitor on y_we
    always @(negedge clk) begin
        if (reset) begin
            acc = 0;
            for (int k = 0; k < MAC_LAT; k++) prod[k] = 0;
        end else begin
            if (done) done_cnt++;
            if (accum_we) begin
                accw_cnt++;
                acc += prod[MAC_LAT-1];
            end
            for (int k = MAC_LAT-1; k > 0; k--) prod[k] = prod[k-1];
            prod[0] = longint'($signed(mac_x)) * longint'($signed(mac_w));
            if (y_we) begin
                if (sb_q.size() == 0) begin
                    check("y_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("y_addr", longint'(y_addr), longint'(e.addr));
                    check("y_value", ymod, e.acc);
                    check("mac_reset_with_y", longint'(mac_reset), 1);
                end
            end
            if (out_en) begin
                outen_cnt++;
                ymod = acc;
            end
            if (mac_reset) acc = 0;
        end
    end

    // Reference: dot product of input vector with each neuron's weight row
    task automatic push_job(input int nin, input int nout);
        for (int o = 0; o < nout; o++) begin
            exp_t e;
            e.addr = o;
            e.acc  = 0;
            for (int i = 0; i < nin; i++) begin
                e.acc += longint'($signed(x_mem[i])) *
                         longint'($signed(w_mem[(o * nin + i) % 65536]));
            end
`ifdef MAC_SEQ_BIAS_EN
            e.acc += 256 * longint'($signed(b_mem[o]));
`endif
            sb_q.push_back(e);
        end
    endtask

    task automatic run_job(input int nin, input int nout, input bit poke);
        int c0, d0, a0, e0, per, exp_lat;
        @(negedge clk);
        n_in  = CWIDTH'(nin);
        n_out = CWIDTH'(nout);
        start = 1'b1;
        push_job(nin, nout);
        c0 = cyc;
        d0 = done_cnt;
        a0 = accw_cnt;
        e0 = outen_cnt;
        per = (nin == 0 && BIAS == 0) ? 2 : nin + RD_LAT + MAC_LAT + 2 + BIAS;
        exp_lat = nout * per + 1;
        @(negedge clk);
        start = 1'b0;
        n_in  = CWIDTH'($urandom);
        n_out = CWIDTH'($urandom);
        if (nout > 0) check("busy_after_start", longint'(busy), 1);
        while (!done && (cyc - c0) < exp_lat + 50) begin
            if (poke && cyc == c0 + 3) begin
                start = 1'b1;
                n_in  = CWIDTH'($urandom_range(1, 7));
                n_out = CWIDTH'($urandom_range(1, 7));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!done) begin
            check("done_timeout", 0, 1);
        end else begin
            check("done_latency", longint'(cyc - c0), longint'(exp_lat));
            check("busy_at_done", longint'(busy), 0);
        end
        @(negedge clk);
        check("done_count", longint'(done_cnt - d0), 1);
        check("accum_we_count", longint'(accw_cnt - a0), longint'(nout * (nin + BIAS)));
        check("out_en_count", longint'(outen_cnt - e0), longint'(nout));
        check("sb_drained", longint'(sb_q.size()), 0);
        sb_q.delete();
    endtask

    function automatic logic outputs_nonzero();
        logic nz;
        nz = |{busy, done, x_addr, w_addr, mac_x, mac_w, accum_we, out_en,
               mac_reset, y_we, y_addr};
`ifdef MAC_SEQ_BIAS_EN
        nz = nz | (|b_addr);
`endif
        return nz;
    endfunction

    task automatic reset_mid_fetch();
        int c0, d0;
        @(negedge clk);
        n_in  = CWIDTH'(5);
        n_out = CWIDTH'(2);
        start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        while (!(busy && x_addr == IAWIDTH'(2)) && (cyc - c0) < 20) @(negedge clk);
        check("reached_elem2", longint'(x_addr), 2);
        d0 = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        check("outputs_after_reset", longint'(outputs_nonzero()), 0);
        reset = 1'b0;
        sb_q.delete();
        repeat (15) @(negedge clk);
        check("no_done_after_reset", longint'(done_cnt - d0), 0);
        check("idle_after_reset", longint'(busy), 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) x_mem[i] = DWIDTH'($urandom);
        for (int i = 0; i < 65536; i++) w_mem[i] = DWIDTH'($urandom);
`ifdef MAC_SEQ_BIAS_EN
        for (int i = 0; i < 4096; i++) b_mem[i] = DWIDTH'($urandom);
`endif
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state", longint'(outputs_nonzero()), 0);
        reset = 1'b0;

        run_job(4, 1, 1'b0);
        run_job(3, 3, 1'b0);
        run_job(0, 1, 1'b0);
        run_job(0, 3, 1'b0);
        run_job(5, 0, 1'b0);
        run_job(1, 2, 1'b0);
        run_job(3, 3, 1'b1);
        reset_mid_fetch();
        run_job(4, 2, 1'b0);
        for (int j = 0; j < 12; j++) begin
            run_job(int'($urandom_range(0, 9)), int'($urandom_range(0, 5)), j[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
